// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer for ARM data-processing instructions:
// fetch, condition check, operand read, execute and write-back.
module dp_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [7:0]  shift_amt,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  flags,
  output logic        retired
);

  typedef enum logic [2:0] {
    IDLE, FETCH, COND, READ, RSREAD, EXEC, WB
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic        cond_pass;
  logic        is_dp;
  logic        do_write;
  logic        n, z, c, v;

  assign {n, z, c, v} = flags;
  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign rf_raddr_a = (state == RSREAD) ? instr[11:8] : instr[19:16];
  assign rf_raddr_b = instr[3:0];

  // Test/compare ops without S are other instruction classes
  assign is_dp    = (instr[27:26] == 2'b00) &&
                    !((instr[24:23] == 2'b10) && !instr[20]);
  assign do_write = (instr[24:23] != 2'b10);

  always_comb begin
    cond_pass = 1'b0;
    case (instr[31:28])
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   state_next = FETCH;
      FETCH:  if (imem_ack) state_next = COND;
      COND:   state_next = (cond_pass && is_dp) ? READ : FETCH;
      READ:   state_next = (!instr[25] && instr[4]) ? RSREAD : EXEC;
      RSREAD: state_next = EXEC;
      EXEC:   state_next = WB;
      WB:     state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      instr     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      shift_amt <= '0;
      flags     <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      retired   <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      retired <= 1'b0;
      case (state)
        FETCH: if (imem_ack) instr <= imem_rdata;
        COND: begin
          if (!(cond_pass && is_dp)) begin
            retired <= 1'b1;
            pc      <= pc + PC_STEP;
          end
        end
        READ: begin
          op_a <= rf_rdata_a;
          op_b <= rf_rdata_b;
        end
        RSREAD: shift_amt <= rf_rdata_a[7:0];
        WB: begin
          retired <= 1'b1;
          if (instr[20]) flags <= alu_flags;
          // A write to r15 becomes a branch
          if (do_write && instr[15:12] == 4'hF) begin
            pc <= alu_result & 32'hFFFF_FFFC;
          end else begin
            pc <= pc + PC_STEP;
            if (do_write) begin
              rf_we    <= 1'b1;
              rf_waddr <= instr[15:12];
              rf_wdata <= alu_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: directed scenarios then random instruction
// words checked against an instruction-level reference model.
module tb_dp_sequencer;

  logic        clk = 0;
  logic        rst = 1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 0;
  logic [31:0] imem_rdata = 0;
  logic [31:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic [31:0] op_a, op_b;
  logic [7:0]  shift_amt;
  logic [31:0] alu_result = 0;
  logic [3:0]  alu_flags = 0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  flags;
  logic        retired;

  logic [31:0] rf [16];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mpc = 0;
  logic [3:0]  mflags = 0;

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always #5 clk = ~clk;

  dp_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .op_a(op_a), .op_b(op_b), .shift_amt(shift_amt),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags(flags), .retired(retired)
  );

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit nn, zz, cf, vv, b;
    {nn, zz, cf, vv} = f;
    case (cc[3:1])
      3'd0: b = zz;
      3'd1: b = cf;
      3'd2: b = nn;
      3'd3: b = vv;
      3'd4: b = cf && !zz;
      3'd5: b = (nn == vv);
      3'd6: b = !zz && (nn == vv);
      default: b = 1;
    endcase
    return cc[0] ? !b : b;
  endfunction

  task automatic run_instr(
    input  logic [31:0] word, input int w,
    input  logic [31:0] res, input logic [3:0] fl,
    input  int abort_at, input bit noise,
    output int cyc, output int nwe,
    output logic [3:0] wa, output logic [31:0] wd,
    output bit stable, output bit tmo);
    int g;
    logic [31:0] a0;
    cyc = 0; nwe = 0; wa = 0; wd = 0; stable = 1; tmo = 0;
    alu_result = res;
    alu_flags = fl;
    g = 0;
    while (!imem_req && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (!imem_req) begin
      tmo = 1;
      return;
    end
    a0 = imem_addr;
    cyc = 1;
    for (int i = 0; i < w; i++) begin
      imem_ack = 0;
      @(negedge clk);
      cyc++;
      if (!imem_req || imem_addr !== a0) stable = 0;
    end
    imem_ack = 1;
    imem_rdata = word;
    for (g = 0; g < 20; g++) begin
      @(negedge clk);
      imem_ack = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      imem_rdata = $urandom;
      if (rf_we) begin
        nwe++;
        wa = rf_waddr;
        wd = rf_wdata;
        rf[rf_waddr] = rf_wdata;
      end
      if (retired) break;
      cyc++;
      if (abort_at != 0 && cyc == abort_at) begin
        imem_ack = 0;
        rst = 1;
        return;
      end
    end
    imem_ack = 0;
    if (g == 20) tmo = 1;
  endtask

  task automatic test_reset();
    int g;
    rst = 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (imem_req !== 0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_checks++;
    if (imem_addr !== 0) begin n_fail++; $display("FAIL reset_pc got %h want 0", imem_addr); end
    n_checks++;
    if ({instr, op_a, op_b, shift_amt} !== '0) begin
      n_fail++; $display("FAIL reset_regs got %h %h %h %h want 0", instr, op_a, op_b, shift_amt);
    end
    n_checks++;
    if ({flags, rf_we, retired} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b %b %b want 0", flags, rf_we, retired);
    end
    rst = 0;
    g = 0;
    while (!imem_req && g < 2) begin @(negedge clk); g++; end
    n_checks++;
    if (imem_req !== 1 || imem_addr !== 0) begin
      n_fail++; $display("FAIL reset_fetch got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    mpc = 0;
    mflags = 0;
  endtask

  task automatic test_add();
    int cyc, nwe; logic [3:0] wa; logic [31:0] wd; bit st, to;
    rf[2] = 5; rf[3] = 7;
    run_instr(32'hE0821003, 0, 32'd12, 4'hF, 0, 0, cyc, nwe, wa, wd, st, to);
    mpc += 4;
    n_checks++;
    if (to || cyc != 5) begin n_fail++; $display("FAIL add_cycles got %0d to=%b want 5", cyc, to); end
    n_checks++;
    if (nwe != 1 || wa !== 1 || wd !== 12) begin
      n_fail++; $display("FAIL add_write got n=%0d a=%0d d=%h want 1 1 c", nwe, wa, wd);
    end
    n_checks++;
    if (imem_addr !== mpc || flags !== mflags) begin
      n_fail++; $display("FAIL add_pc_flags got %h %b want %h %b", imem_addr, flags, mpc, mflags);
    end
    n_checks++;
    if (op_a !== 5 || op_b !== 7) begin
      n_fail++; $display("FAIL add_ops got %h %h want 5 7", op_a, op_b);
    end
  endtask

  task automatic test_cond_fail();
    int cyc, nwe; logic [3:0] wa; logic [31:0] wd; bit st, to;
    run_instr(32'h00821003, 0, 32'd99, 4'hF, 0, 0, cyc, nwe, wa, wd, st, to);
    mpc += 4;
    n_checks++;
    if (to || cyc != 2 || nwe != 0) begin
      n_fail++; $display("FAIL condfail got cyc=%0d we=%0d want 2 0", cyc, nwe);
    end
    n_checks++;
    if (imem_addr !== mpc) begin n_fail++; $display("FAIL condfail_pc got %h want %h", imem_addr, mpc); end
  endtask

  task automatic test_rsread();
    int cyc, nwe; logic [3:0] wa; logic [31:0] wd; bit st, to;
    rf[2] = 32'h11; rf[3] = 32'h105;
    run_instr(32'hE0821312, 0, 32'hABC, 4'h0, 0, 0, cyc, nwe, wa, wd, st, to);
    mpc += 4;
    n_checks++;
    if (to || cyc != 6) begin n_fail++; $display("FAIL rsread_cycles got %0d want 6", cyc); end
    n_checks++;
    if (shift_amt !== 8'h05) begin n_fail++; $display("FAIL rsread_amt got %h want 05", shift_amt); end
    n_checks++;
    if (nwe != 1 || wa !== 1 || wd !== 32'hABC || imem_addr !== mpc) begin
      n_fail++; $display("FAIL rsread_wb got n=%0d a=%0d d=%h pc=%h", nwe, wa, wd, imem_addr);
    end
  endtask

  task automatic test_cmp();
    int cyc, nwe; logic [3:0] wa; logic [31:0] wd; bit st, to;
    run_instr(32'hE1520003, 0, 32'h5, 4'b0100, 0, 0, cyc, nwe, wa, wd, st, to);
    mpc += 4;
    mflags = 4'b0100;
    n_checks++;
    if (to || cyc != 5 || nwe != 0) begin
      n_fail++; $display("FAIL cmp got cyc=%0d we=%0d want 5 0", cyc, nwe);
    end
    n_checks++;
    if (flags !== mflags || imem_addr !== mpc) begin
      n_fail++; $display("FAIL cmp_flags got %b pc=%h want %b %h", flags, imem_addr, mflags, mpc);
    end
  endtask

  task automatic test_wait_pc15();
    int cyc, nwe; logic [3:0] wa; logic [31:0] wd; bit st, to;
    run_instr(32'hE082F003, 3, 32'h103, 4'hF, 0, 0, cyc, nwe, wa, wd, st, to);
    mpc = 32'h100;
    n_checks++;
    if (!st) begin n_fail++; $display("FAIL wait_stable got 0 want 1"); end
    n_checks++;
    if (to || cyc != 8 || nwe != 0) begin
      n_fail++; $display("FAIL wait_cycles got %0d we=%0d want 8 0", cyc, nwe);
    end
    n_checks++;
    if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL pc15 got %h want 100", imem_addr); end
  endtask

  task automatic test_reset_mid();
    int cyc, nwe, g; logic [3:0] wa; logic [31:0] wd; bit st, to, we_seen;
    run_instr(32'hE0921003, 0, 32'h77, 4'hA, 4, 0, cyc, nwe, wa, wd, st, to);
    #1;
    n_checks++;
    if (to || rf_we !== 0 || imem_req !== 0 || imem_addr !== 0) begin
      n_fail++; $display("FAIL midrst got we=%b req=%b pc=%h want 0 0 0", rf_we, imem_req, imem_addr);
    end
    n_checks++;
    if (flags !== 0 || retired !== 0) begin
      n_fail++; $display("FAIL midrst_flags got %b ret=%b want 0 0", flags, retired);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    mpc = 0;
    mflags = 0;
    g = 0;
    we_seen = 0;
    while (!imem_req && g < 2) begin
      @(negedge clk);
      g++;
      if (rf_we) we_seen = 1;
    end
    n_checks++;
    if (imem_req !== 1 || imem_addr !== 0 || we_seen) begin
      n_fail++; $display("FAIL midrst_fetch got req=%b addr=%h we=%b", imem_req, imem_addr, we_seen);
    end
  endtask

  task automatic test_random();
    int cyc, nwe, wt, ecyc, enwe;
    logic [3:0] wa, rd; logic [31:0] wd, w, res, ea, eb, npc;
    logic [3:0] fl; logic [7:0] es;
    bit st, to, dp, ok, rs, wr;
    for (int k = 0; k < 16; k++) rf[k] = $urandom;
    for (int t = 0; t < 80; t++) begin
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[27:26] = 2'b00;
      if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
      wt = $urandom_range(0, 3);
      res = $urandom;
      fl = $urandom;
      dp = (w[27:26] == 0) && !(w[24:23] == 2'b10 && !w[20]);
      ok = cond_ok(w[31:28], mflags);
      rs = !w[25] && w[4];
      wr = (w[24:23] != 2'b10);
      rd = w[15:12];
      ea = rf[w[19:16]];
      eb = rf[w[3:0]];
      es = rf[w[11:8]][7:0];
      enwe = 0;
      npc = mpc + 4;
      if (ok && dp) begin
        ecyc = 5 + int'(rs) + wt;
        if (wr && rd == 15) npc = res & 32'hFFFF_FFFC;
        else if (wr) enwe = 1;
      end else begin
        ecyc = 2 + wt;
      end
      run_instr(w, wt, res, fl, 0, 1, cyc, nwe, wa, wd, st, to);
      if (ok && dp && w[20]) mflags = fl;
      mpc = npc;
      n_checks++;
      if (to || cyc != ecyc || !st) begin
        n_fail++; $display("FAIL rnd_cycles %h got %0d st=%b want %0d", w, cyc, st, ecyc);
      end
      n_checks++;
      if (nwe != enwe || (enwe == 1 && (wa !== rd || wd !== res))) begin
        n_fail++; $display("FAIL rnd_write %h got n=%0d a=%0d d=%h want %0d %0d %h", w, nwe, wa, wd, enwe, rd, res);
      end
      n_checks++;
      if (imem_addr !== mpc || flags !== mflags) begin
        n_fail++; $display("FAIL rnd_state %h got pc=%h f=%b want %h %b", w, imem_addr, flags, mpc, mflags);
      end
      if (ok && dp) begin
        n_checks++;
        if (op_a !== ea || op_b !== eb || (rs && shift_amt !== es)) begin
          n_fail++; $display("FAIL rnd_ops %h got %h %h %h want %h %h %h", w, op_a, op_b, shift_amt, ea, eb, es);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rf[k] = 0;
    test_reset();
    test_add();
    test_cond_fail();
    test_rsread();
    test_cmp();
    test_wait_pc15();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
